multi_mode_ring_counter: RTL and testbench

MULTI_MODE_RING_COUNTER -- requirements
Module: multi_mode_ring_counter

---
 rtl/multi_mode_ring_counter.sv | 105 ++++++++++
 tb/tb_multi_mode_ring_counter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_mode_ring_counter.sv
// Ring / Johnson counter with direction, parallel load,
// wrap detection and optional illegal-state correction.
module multi_mode_ring_counter #(
  parameter int              WIDTH       = 8,
  parameter logic [WIDTH-1:0] INIT       = {1'b1, {WIDTH-1{1'b0}}},
  parameter int              AUTOCORRECT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             wrap,
  output logic             err
);

  localparam int CW = $clog2(2*WIDTH) + 1;
  localparam int PW = $clog2(WIDTH+1);

  logic [CW-1:0]    cnt;
  logic [CW-1:0]    base;
  logic [CW-1:0]    cnt_inc;
  logic [CW-1:0]    period;
  logic [1:0]       prev_mode;
  logic [WIDTH-1:0] mis;
  logic [WIDTH-1:0] shifted;
  logic [PW-1:0]    ones;
  logic [PW-1:0]    mis_cnt;
  logic             ring_ok;
  logic             john_ok;
  logic             legal;
  logic             active;
  logic             fix;
  logic             feed_r;
  logic             feed_l;
  logic             at_wrap;

  // mis[i] flags out[i] != out[(i+1) mod WIDTH]
  assign mis = out ^ {out[0], out[WIDTH-1:1]};

  always_comb begin
    ones    = '0;
    mis_cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ones    = ones + PW'(out[i]);
      mis_cnt = mis_cnt + PW'(mis[i]);
    end
  end

  assign ring_ok = (ones == PW'(1));
  assign john_ok = (mis_cnt == PW'(0))
                || (mis_cnt == PW'(2));
  assign legal   = mode[0] ? john_ok : ring_ok;
  assign active  = en && !mode[1];
  assign fix     = active && (AUTOCORRECT != 0)
                && !legal;

  assign feed_r  = mode[0] ? ~out[0] : out[0];
  assign feed_l  = mode[0] ? ~out[WIDTH-1]
                           : out[WIDTH-1];
  assign shifted = dir ? {out[WIDTH-2:0], feed_l}
                       : {feed_r, out[WIDTH-1:1]};

  // A mode switch restarts the period with this shift
  assign base    = (mode != prev_mode) ? '0 : cnt;
  assign cnt_inc = base + CW'(1);
  assign period  = mode[0] ? CW'(2*WIDTH)
                           : CW'(WIDTH);
  assign at_wrap = (cnt_inc == period);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out       <= INIT;
      cnt       <= '0;
      prev_mode <= 2'b00;
      wrap      <= 1'b0;
      err       <= 1'b0;
    end else begin
      wrap <= 1'b0;
      err  <= 1'b0;
      if (load) begin
        out <= load_val;
        cnt <= '0;
      end else if (fix) begin
        out       <= INIT;
        cnt       <= '0;
        prev_mode <= mode;
        err       <= 1'b1;
      end else if (active) begin
        out       <= shifted;
        prev_mode <= mode;
        if (at_wrap) begin
          cnt  <= '0;
          wrap <= 1'b1;
        end else begin
          cnt <= cnt_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_mode_ring_counter.sv
// Bench: directed sequences plus random traffic against
// a behavioural model, for corrected and raw instances.
module tb_multi_mode_ring_counter;

  localparam int W    = 8;
  localparam int INIT = 128;

  typedef struct {
    int out;
    int steps;
    int prev;
    bit wrap;
    bit err;
  } model_t;

  logic         clk;
  logic         reset;
  logic         en;
  logic         dir;
  logic [1:0]   mode;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] out_a, out_n;
  logic         wrap_a, wrap_n;
  logic         err_a, err_n;

  logic [W-1:0] d_out [2];
  logic         d_wrap [2];
  logic         d_err [2];
  model_t       m [2];

  int checks   = 0;
  int failures = 0;
  int wraps;

  assign d_out[0]  = out_a;
  assign d_out[1]  = out_n;
  assign d_wrap[0] = wrap_a;
  assign d_wrap[1] = wrap_n;
  assign d_err[0]  = err_a;
  assign d_err[1]  = err_n;

  multi_mode_ring_counter #(.WIDTH(W)) u_ac (
    .clk(clk), .reset(reset), .en(en), .dir(dir),
    .mode(mode), .load(load), .load_val(load_val),
    .out(out_a), .wrap(wrap_a), .err(err_a)
  );

  multi_mode_ring_counter #(
    .WIDTH(W), .AUTOCORRECT(0)
  ) u_nc (
    .clk(clk), .reset(reset), .en(en), .dir(dir),
    .mode(mode), .load(load), .load_val(load_val),
    .out(out_n), .wrap(wrap_n), .err(err_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int popc(int v);
    int c = 0;
    for (int i = 0; i < W; i++) c += (v >> i) & 1;
    return c;
  endfunction

  function automatic int trans(int v);
    int c = 0;
    for (int i = 0; i < W; i++)
      if (((v >> i) & 1) != ((v >> ((i + 1) % W)) & 1))
        c++;
    return c;
  endfunction

  function automatic int shift_v(int v, bit d, bit jn);
    int fb;
    if (!d) begin
      fb = v % 2;
      if (jn) fb = 1 - fb;
      return (v / 2) + fb * (1 << (W - 1));
    end
    fb = v / (1 << (W - 1));
    if (jn) fb = 1 - fb;
    return ((v * 2) % (1 << W)) + fb;
  endfunction

  function automatic model_t step_m(model_t s, bit ac);
    model_t n = s;
    int md = int'(mode);
    int per = (md == 1) ? 2 * W : W;
    bit ok;
    n.wrap = 1'b0;
    n.err  = 1'b0;
    if (load) begin
      n.out   = int'(load_val);
      n.steps = 0;
    end else if (en && md < 2) begin
      if (md == 0) ok = (popc(s.out) == 1);
      else ok = (trans(s.out) == 0) || (trans(s.out) == 2);
      if (!ok && ac) begin
        n.out   = INIT;
        n.steps = 0;
        n.err   = 1'b1;
        n.prev  = md;
      end else begin
        if (md != s.prev) n.steps = 0;
        n.prev  = md;
        n.steps = n.steps + 1;
        if (n.steps == per) begin
          n.steps = 0;
          n.wrap  = 1'b1;
        end
        n.out = shift_v(s.out, dir, md == 1);
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge reset) begin
    for (int k = 0; k < 2; k++) begin
      if (!reset)
        m[k] <= '{INIT, 0, 0, 1'b0, 1'b0};
      else
        m[k] <= step_m(m[k], k == 0);
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (d_out[k] !== W'(m[k].out)
          || d_wrap[k] !== m[k].wrap
          || d_err[k] !== m[k].err) begin
        failures++;
        $display("FAIL model k=%0d out=%h/%b/%b exp=%h/%b/%b",
                 k, d_out[k], d_wrap[k], d_err[k],
                 W'(m[k].out), m[k].wrap, m[k].err);
      end
    end
  end

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b0;
    #1 reset = 1'b1;
  endtask

  int ring_r [8] = '{8'h40, 8'h20, 8'h10, 8'h08,
                     8'h04, 8'h02, 8'h01, 8'h80};
  int john [16]  = '{8'h80, 8'hC0, 8'hE0, 8'hF0,
                     8'hF8, 8'hFC, 8'hFE, 8'hFF,
                     8'h7F, 8'h3F, 8'h1F, 8'h0F,
                     8'h07, 8'h03, 8'h01, 8'h00};

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int r;
    reset    = 1'b1;
    en       = 1'b0;
    dir      = 1'b0;
    mode     = 2'b00;
    load     = 1'b0;
    load_val = '0;
    #1 reset = 1'b0;
    tick();
    chk("rst_out", int'(out_a), 8'h80);
    chk("rst_wrap", int'(wrap_a), 0);
    chk("rst_err", int'(err_a), 0);
    #2 reset = 1'b1;

    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("ring_r_out", int'(out_a), ring_r[i]);
      chk("ring_r_wrap", int'(wrap_a), (i == 7) ? 1 : 0);
    end

    en = 1'b0;
    pulse_reset();
    dir = 1'b1;
    en  = 1'b1;
    tick(); chk("ring_l_1", int'(out_a), 8'h01);
    tick(); chk("ring_l_2", int'(out_a), 8'h02);
    tick(); chk("ring_l_3", int'(out_a), 8'h04);
    dir = 1'b0;
    tick(); chk("dir_flip", int'(out_a), 8'h02);

    en       = 1'b0;
    load     = 1'b1;
    load_val = 8'h00;
    tick(); chk("load_00", int'(out_a), 8'h00);
    load  = 1'b0;
    mode  = 2'b01;
    en    = 1'b1;
    wraps = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("john_out", int'(out_a), john[i]);
      chk("john_wrap", int'(wrap_a), (i == 15) ? 1 : 0);
      wraps += int'(wrap_a);
    end
    chk("john_wraps", wraps, 1);

    en       = 1'b0;
    mode     = 2'b00;
    load     = 1'b1;
    load_val = 8'h05;
    tick();
    load = 1'b0;
    en   = 1'b1;
    tick();
    chk("fix_out", int'(out_a), 8'h80);
    chk("fix_err", int'(err_a), 1);
    chk("fix_wrap", int'(wrap_a), 0);
    chk("raw_out", int'(out_n), 8'h82);
    chk("raw_err", int'(err_n), 0);
    tick();
    chk("fix_err_clr", int'(err_a), 0);
    load     = 1'b1;
    load_val = 8'h3C;
    tick();
    chk("load_en", int'(out_a), 8'h3C);
    load = 1'b0;

    en = 1'b0;
    pulse_reset();
    en = 1'b1;
    tick(); tick(); tick();
    chk("pre_async", int'(out_a), 8'h10);
    #2 reset = 1'b0;
    #1;
    chk("async_out", int'(out_a), 8'h80);
    chk("async_wrap", int'(wrap_a), 0);
    chk("async_err", int'(err_a), 0);
    #1 reset = 1'b1;
    tick(); tick();
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold", int'(out_a), 8'h20);
    end

    for (int i = 0; i < 3000; i++) begin
      en  = ($urandom_range(0, 3) != 0);
      dir = $urandom_range(0, 1) == 1;
      r   = $urandom_range(0, 15);
      mode = (r < 7) ? 2'b00 : (r < 14) ? 2'b01
           : (r == 14) ? 2'b10 : 2'b11;
      load = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 1) == 1)
        load_val = W'(1 << $urandom_range(0, W - 1));
      else
        load_val = W'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        #1 reset = 1'b0;
        #1 reset = 1'b1;
      end
      tick();
    end

    en   = 1'b0;
    load = 1'b0;
    tick();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
